// File: rtl/pbus_xbar_if.sv
// Peripheral bus signal bundle. N is the number of request/response lanes:
// 1 on the master side, SLAVE_CNT on the slave fan-out side.
interface pbus_xbar_if #(
    parameter int XLEN      = 32,
    parameter int BUS_WIDTH = 32,
    parameter int ACC_W     = 2,
    parameter int N         = 1
);
    logic [N-1:0]           req;
    logic [XLEN-1:0]        addr;
    logic                   w_rb;
    logic [ACC_W-1:0]       acc;
    logic [BUS_WIDTH-1:0]   wdata;
    logic [N-1:0]           resp;
    logic [N*BUS_WIDTH-1:0] rdata;

    modport master (output req, addr, w_rb, acc, wdata, input  resp, rdata);
    modport slave  (input  req, addr, w_rb, acc, wdata, output resp, rdata);
endinterface

// File: rtl/pbus_xbar.sv
// Single-master peripheral crossbar: address decode, response routing,
// wait timeout and halt handling with one-cycle fault reporting.
//
// state | meaning
// IDLE  | ready; request decoded and forwarded in the same cycle
// WAIT  | request forwarded, waiting on the selected slave
// HOLD  | response captured during halt, delivered once halt drops
// ERR   | fault cycle: bus_fault and an empty response to the master
module pbus_xbar #(
    parameter int XLEN        = 32,
    parameter int BUS_WIDTH   = 32,
    parameter int BUS_ACC_CNT = 3,
    parameter int SLAVE_CNT   = 5,
    parameter logic [XLEN-1:0] RST_BASE  = 32'h1000_0000,
    parameter logic [XLEN-1:0] TMR_BASE  = 32'h1000_1000,
    parameter logic [XLEN-1:0] GPIO_BASE = 32'h1000_2000,
    parameter logic [XLEN-1:0] UART_BASE = 32'h1000_3000,
    parameter logic [XLEN-1:0] EIC_BASE  = 32'h1000_4000,
    parameter logic [SLAVE_CNT*XLEN-1:0] SLAVE_BASE =
        {RST_BASE, TMR_BASE, GPIO_BASE, UART_BASE, EIC_BASE},
    parameter logic [SLAVE_CNT*8-1:0] SLAVE_SPAN = {5{8'd12}},
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    pbus_xbar_if.slave      m,
    pbus_xbar_if.master     s,
    output logic            bus_fault,
    output logic [XLEN-1:0] bus_fault_addr,
    output logic [1:0]      bus_fault_cause,
    input  logic            bus_halt
);
    localparam int SEL_W = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, ERR} state_t;

    state_t                 state;
    logic [SEL_W-1:0]       sel;
    logic [SEL_W-1:0]       hit_idx;
    logic [SLAVE_CNT-1:0]   hit;
    logic [XLEN-1:0]        mask;
    logic [XLEN-1:0]        addr_q;
    logic [CNT_W-1:0]       cnt;
    logic [BUS_WIDTH-1:0]   rdata_q;
    logic [BUS_WIDTH-1:0]   hold_q;
    logic [BUS_WIDTH-1:0]   issue_data;
    logic [BUS_WIDTH-1:0]   sel_data;
    logic [BUS_WIDTH-1:0]   deliver_data;
    logic                   hit_any;
    logic                   issue;
    logic                   miss;
    logic                   issue_resp;
    logic                   wait_resp;
    logic                   deliver;
    logic                   timed_out;

    always_comb begin
        hit  = '0;
        mask = '0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            mask   = ~((XLEN'(1) << SLAVE_SPAN[i*8 +: 8]) - XLEN'(1));
            hit[i] = (m.addr & mask) == SLAVE_BASE[i*XLEN +: XLEN];
        end
        hit_idx = '0;
        for (int i = SLAVE_CNT - 1; i >= 0; i--)
            if (hit[i]) hit_idx = SEL_W'(i);
    end

    assign hit_any    = |hit;
    assign issue      = !rst && state == IDLE && m.req[0] && !bus_halt && hit_any;
    assign miss       = state == IDLE && m.req[0] && !bus_halt && !hit_any;
    assign issue_data = s.rdata[hit_idx*BUS_WIDTH +: BUS_WIDTH];
    assign sel_data   = s.rdata[sel*BUS_WIDTH +: BUS_WIDTH];
    assign issue_resp = issue && s.resp[hit_idx];
    assign wait_resp  = state == WAIT && s.resp[sel];

    // cnt counts WAIT cycles after the request cycle; the +2 makes the fault
    // cycle land exactly TIMEOUT cycles after the request.
    assign timed_out  = (TIMEOUT > 0) && (int'(cnt) + 2 >= TIMEOUT);

    assign deliver = !rst && !bus_halt &&
                     (issue_resp || wait_resp || state == HOLD || state == ERR);

    always_comb begin
        case (state)
            ERR:     deliver_data = '0;
            HOLD:    deliver_data = hold_q;
            WAIT:    deliver_data = sel_data;
            default: deliver_data = issue_data;
        endcase
    end

    assign s.req     = issue ? (SLAVE_CNT'(1) << hit_idx) : '0;
    assign s.addr    = m.addr;
    assign s.w_rb    = m.w_rb;
    assign s.acc     = m.acc;
    assign s.wdata   = m.wdata;
    assign m.resp[0] = deliver;
    assign m.rdata   = deliver ? deliver_data : rdata_q;
    assign bus_fault = !rst && !bus_halt && state == ERR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            sel             <= '0;
            cnt             <= '0;
            addr_q          <= '0;
            rdata_q         <= '0;
            hold_q          <= '0;
            bus_fault_addr  <= '0;
            bus_fault_cause <= 2'b00;
        end else begin
            if (deliver) rdata_q <= deliver_data;
            case (state)
                IDLE: begin
                    if (issue) begin
                        sel    <= hit_idx;
                        cnt    <= '0;
                        addr_q <= m.addr;
                        if (!issue_resp) state <= WAIT;
                    end else if (miss) begin
                        bus_fault_addr  <= m.addr;
                        bus_fault_cause <= 2'b01;
                        state           <= ERR;
                    end
                end
                WAIT: begin
                    if (s.resp[sel]) begin
                        if (bus_halt) begin
                            hold_q <= sel_data;
                            state  <= HOLD;
                        end else begin
                            state  <= IDLE;
                        end
                    end else if (timed_out) begin
                        // counter stays frozen while a halt defers the fault
                        if (!bus_halt) begin
                            bus_fault_addr  <= addr_q;
                            bus_fault_cause <= 2'b10;
                            state           <= ERR;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: if (!bus_halt) state <= IDLE;
                ERR:  if (!bus_halt) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pbus_xbar.sv
// Directed-vector bench for pbus_xbar: decode, response routing, timeout,
// halt and reset behaviour with hand-computed expectations.
module tb_pbus_xbar;
    localparam logic [31:0] TMR_A  = 32'h1000_1000;
    localparam logic [31:0] GPIO_A = 32'h1000_2000;
    localparam logic [31:0] UART_A = 32'h1000_3000;
    localparam logic [31:0] EIC_A  = 32'h1000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_halt;
    logic        bus_fault;
    logic [31:0] bus_fault_addr;
    logic [1:0]  bus_fault_cause;
    int          n_vec = 0;
    int          n_bad = 0;

    pbus_xbar_if #(.XLEN(32), .BUS_WIDTH(32), .ACC_W(2), .N(1)) mbus ();
    pbus_xbar_if #(.XLEN(32), .BUS_WIDTH(32), .ACC_W(2), .N(5)) sbus ();

    pbus_xbar #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .m               (mbus),
        .s               (sbus),
        .bus_fault       (bus_fault),
        .bus_fault_addr  (bus_fault_addr),
        .bus_fault_cause (bus_fault_cause),
        .bus_halt        (bus_halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle, sample mid-cycle
    task automatic probe();
        #4;
    endtask

    task automatic quiet();
        mbus.req  = 1'b0;
        sbus.resp = '0;
    endtask

    task automatic issue(input logic [31:0] a);
        mbus.req  = 1'b1;
        mbus.addr = a;
        mbus.w_rb = 1'b0;
    endtask

    task automatic sresp(input int idx, input logic [31:0] d);
        sbus.resp      = 5'(1 << idx);
        sbus.rdata[idx*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus_halt   = 1'b0;
        mbus.req   = 1'b1;
        mbus.addr  = UART_A;
        mbus.w_rb  = 1'b0;
        mbus.acc   = 2'd2;
        mbus.wdata = 32'hDEAD_BEEF;
        sbus.resp  = 5'b00010;
        sbus.rdata = '0;
        sbus.rdata[63:32] = 32'hCAFE;

        // outputs quiet while in reset even with a live request
        probe();
        chk("rst_s_req",  64'(sbus.req), 64'h0);
        chk("rst_m_resp", 64'(mbus.resp), 64'h0);
        chk("rst_fault",  64'(bus_fault), 64'h0);
        chk("rst_rdata",  64'(mbus.rdata), 64'h0);
        chk("rst_faddr",  64'(bus_fault_addr), 64'h0);
        chk("rst_cause",  64'(bus_fault_cause), 64'h0);
        tick();
        quiet();
        rst = 1'b0;
        tick();

        // UART read, response after 3 cycles
        issue(UART_A + 32'h4);
        probe();
        chk("uart_s_req",  64'(sbus.req), 64'h02);
        chk("uart_s_addr", 64'(sbus.addr), 64'(UART_A + 32'h4));
        chk("uart_s_acc",  64'(sbus.acc), 64'h2);
        chk("uart_resp0",  64'(mbus.resp), 64'h0);
        tick(); quiet(); probe();
        chk("uart_s_req1", 64'(sbus.req), 64'h0);
        chk("uart_resp1",  64'(mbus.resp), 64'h0);
        tick(); probe();
        chk("uart_resp2",  64'(mbus.resp), 64'h0);
        tick(); sresp(1, 32'hA5); probe();
        chk("uart_resp3",  64'(mbus.resp), 64'h1);
        chk("uart_rdata3", 64'(mbus.rdata), 64'hA5);
        tick(); quiet(); sbus.rdata[63:32] = 32'h1234; probe();
        chk("uart_resp4",  64'(mbus.resp), 64'h0);
        chk("uart_hold4",  64'(mbus.rdata), 64'hA5);

        // unmapped address
        tick(); issue(32'h0); probe();
        chk("miss_s_req",  64'(sbus.req), 64'h0);
        chk("miss_fault0", 64'(bus_fault), 64'h0);
        chk("miss_resp0",  64'(mbus.resp), 64'h0);
        tick(); quiet(); probe();
        chk("miss_fault1", 64'(bus_fault), 64'h1);
        chk("miss_cause",  64'(bus_fault_cause), 64'h1);
        chk("miss_faddr",  64'(bus_fault_addr), 64'h0);
        chk("miss_resp1",  64'(mbus.resp), 64'h1);
        chk("miss_rdata",  64'(mbus.rdata), 64'h0);
        tick(); probe();
        chk("miss_fault2", 64'(bus_fault), 64'h0);
        chk("miss_cause2", 64'(bus_fault_cause), 64'h1);

        // second miss latches a non-zero address
        issue(32'h2000_0010);
        tick(); quiet(); probe();
        chk("miss2_faddr", 64'(bus_fault_addr), 64'h2000_0010);
        tick();

        // zero-latency responses back to back: state must stay IDLE
        issue(EIC_A + 32'h10); sresp(0, 32'h33); probe();
        chk("zl_resp0",  64'(mbus.resp), 64'h1);
        chk("zl_rdata0", 64'(mbus.rdata), 64'h33);
        tick(); issue(GPIO_A); sresp(2, 32'h44); probe();
        chk("zl_s_req1", 64'(sbus.req), 64'h04);
        chk("zl_resp1",  64'(mbus.resp), 64'h1);
        chk("zl_rdata1", 64'(mbus.rdata), 64'h44);
        tick(); quiet(); probe();
        chk("zl_resp2",  64'(mbus.resp), 64'h0);

        // slave 2 selected, slave 3 answers spuriously first
        tick(); issue(GPIO_A + 32'h8); probe();
        chk("spur_s_req", 64'(sbus.req), 64'h04);
        tick(); quiet(); sresp(3, 32'hEE); probe();
        chk("spur_resp1", 64'(mbus.resp), 64'h0);
        tick(); sresp(2, 32'h11); probe();
        chk("spur_resp2",  64'(mbus.resp), 64'h1);
        chk("spur_rdata2", 64'(mbus.rdata), 64'h11);
        tick(); quiet(); probe();
        chk("spur_resp3", 64'(mbus.resp), 64'h0);

        // silent slave: fault 4 cycles after request, late response ignored
        tick(); issue(TMR_A + 32'h8); probe();
        tick(); quiet();
        for (int c = 1; c <= 3; c++) begin
            probe();
            chk($sformatf("to_resp%0d", c), 64'(mbus.resp), 64'h0);
            tick();
        end
        probe();
        chk("to_fault",  64'(bus_fault), 64'h1);
        chk("to_cause",  64'(bus_fault_cause), 64'h2);
        chk("to_faddr",  64'(bus_fault_addr), 64'(TMR_A + 32'h8));
        chk("to_resp4",  64'(mbus.resp), 64'h1);
        chk("to_rdata4", 64'(mbus.rdata), 64'h0);
        tick(); sresp(3, 32'h66); probe();
        chk("to_late_resp",  64'(mbus.resp), 64'h0);
        chk("to_late_fault", 64'(bus_fault), 64'h0);

        // response in the timeout cycle wins
        tick(); quiet(); issue(TMR_A); probe();
        tick(); quiet(); probe();
        tick(); probe();
        tick(); sresp(3, 32'h5A); probe();
        chk("race_resp",  64'(mbus.resp), 64'h1);
        chk("race_rdata", 64'(mbus.rdata), 64'h5A);
        chk("race_fault", 64'(bus_fault), 64'h0);
        tick(); quiet(); probe();
        chk("race_fault4", 64'(bus_fault), 64'h0);
        chk("race_resp4",  64'(mbus.resp), 64'h0);
        chk("race_faddr",  64'(bus_fault_addr), 64'(TMR_A + 32'h8));

        // halt while slave 0 responds: held 5 cycles then delivered
        tick(); issue(EIC_A); probe();
        tick(); quiet(); bus_halt = 1'b1; sresp(0, 32'h77); probe();
        chk("halt_resp1", 64'(mbus.resp), 64'h0);
        tick(); quiet(); sbus.rdata[31:0] = 32'h0;
        for (int c = 2; c <= 5; c++) begin
            probe();
            chk($sformatf("halt_resp%0d", c), 64'(mbus.resp), 64'h0);
            tick();
        end
        bus_halt = 1'b0; probe();
        chk("halt_rel_resp",  64'(mbus.resp), 64'h1);
        chk("halt_rel_rdata", 64'(mbus.rdata), 64'h77);
        tick(); probe();
        chk("halt_after", 64'(mbus.resp), 64'h0);

        // requests during halt are dropped without a fault
        tick(); bus_halt = 1'b1; issue(UART_A); sresp(1, 32'h55); probe();
        chk("hdrop_s_req", 64'(sbus.req), 64'h0);
        chk("hdrop_resp",  64'(mbus.resp), 64'h0);
        tick(); issue(32'h0); sbus.resp = '0; probe();
        tick(); quiet(); probe();
        chk("hdrop_fault", 64'(bus_fault), 64'h0);
        chk("hdrop_cause", 64'(bus_fault_cause), 64'h2);
        tick(); bus_halt = 1'b0; issue(UART_A); sresp(1, 32'h56); probe();
        chk("hdrop_next", 64'(mbus.rdata), 64'h56);

        // timeout under halt is deferred until release
        tick(); quiet(); issue(TMR_A + 32'h20); probe();
        tick(); quiet(); probe();
        tick(); probe();
        tick(); bus_halt = 1'b1; probe();
        tick(); probe();
        chk("tdef_fault4", 64'(bus_fault), 64'h0);
        tick(); bus_halt = 1'b0; probe();
        chk("tdef_fault5", 64'(bus_fault), 64'h0);
        tick(); probe();
        chk("tdef_fault6", 64'(bus_fault), 64'h1);
        chk("tdef_faddr",  64'(bus_fault_addr), 64'(TMR_A + 32'h20));

        // request ignored while waiting
        tick(); issue(UART_A); probe();
        tick(); issue(GPIO_A); probe();
        chk("wreq_s_req", 64'(sbus.req), 64'h0);
        tick(); quiet(); sresp(1, 32'h21); probe();
        chk("wreq_resp",  64'(mbus.resp), 64'h1);
        chk("wreq_rdata", 64'(mbus.rdata), 64'h21);

        // reset mid-WAIT abandons the transaction
        tick(); quiet(); issue(UART_A); probe();
        tick(); quiet(); rst = 1'b1; probe();
        chk("rstw_resp", 64'(mbus.resp), 64'h0);
        tick(); rst = 1'b0; sresp(1, 32'h99); probe();
        chk("rstw_late_resp", 64'(mbus.resp), 64'h0);
        chk("rstw_fault",     64'(bus_fault), 64'h0);
        chk("rstw_faddr",     64'(bus_fault_addr), 64'h0);
        chk("rstw_cause",     64'(bus_fault_cause), 64'h0);
        chk("rstw_rdata",     64'(mbus.rdata), 64'h0);
        tick(); quiet(); issue(GPIO_A); sresp(2, 32'hB2); probe();
        chk("rstw_idle_resp", 64'(mbus.resp), 64'h1);
        chk("rstw_idle_data", 64'(mbus.rdata), 64'hB2);
        tick(); quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
